copro_sched: RTL

- Two-requester scheduler in front of the shared co_processor / fault_pro pair.
- Arbitrates the single 8-bit operand bus and 2-bit check code between a host requester (0) and a self-test requester (1).
- Holds the operand stable for a programmable settle time, then captures the Q bit and the 5 fault bits.
- Returns the captured result to the granted requester with a one-cycle done pulse.

---
 rtl/copro_sched_pkg.sv | 16 +
 rtl/copro_sched_rr_arb2.sv | 24 ++
 rtl/copro_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/copro_sched_pkg.sv
// Shared types and constants for the co-processor scheduler.
package copro_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam int REQ_HOST = 0;
    localparam int REQ_BIST = 1;
    localparam int FLT_W    = 5;
    localparam int OP_W     = 8;
    localparam int CHK_W    = 2;

endpackage

// File: rtl/copro_sched_rr_arb2.sv
// Two-way round-robin arbiter; produces a one-hot grant only while enabled (scheduler idle).
module rr_arb2
    import copro_sched_pkg::*;
(
    input  logic       en,
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt[REQ_HOST] = 1'b1;
                2'b10:   gnt[REQ_BIST] = 1'b1;
                // on contention the requester that did not win last time goes first
                2'b11:   gnt[last ? REQ_HOST : REQ_BIST] = 1'b1;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/copro_sched.sv
// Scheduler sharing the co_processor / fault_pro datapath between host and self-test requesters.
// Optional fault-capture counter output enabled by defining COPRO_SCHED_FAULT_LOG_EN.
module copro_sched
    import copro_sched_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [OP_W-1:0]  op0,
    input  logic [CHK_W-1:0] chk0,
    input  logic [OP_W-1:0]  op1,
    input  logic [CHK_W-1:0] chk1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             res_q,
    output logic [FLT_W-1:0] res_flt,
    output logic [OP_W-1:0]  dp_r0,
    output logic [CHK_W-1:0] dp_check,
`ifdef COPRO_SCHED_FAULT_LOG_EN
    output logic [7:0]       flt_cnt,
`endif
    input  logic             dp_q,
    input  logic [2:0]       dp_out,
    input  logic [1:0]       dp_out1
);

    localparam int              SETTLE_EFF = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_EFF - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             last, last_n;
    logic [1:0]       gnt_n, arb_gnt;
    logic             busy_n, done_n, res_q_n;
    logic [FLT_W-1:0] res_flt_n;
    logic [OP_W-1:0]  r0_n;
    logic [CHK_W-1:0] chk_n;

    rr_arb2 u_arb (
        .en   (state == IDLE),
        .req  (req),
        .last (last),
        .gnt  (arb_gnt)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        last_n    = last;
        gnt_n     = gnt;
        busy_n    = busy;
        done_n    = done;
        res_q_n   = res_q;
        res_flt_n = res_flt;
        r0_n      = dp_r0;
        chk_n     = dp_check;
        case (state)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    gnt_n   = arb_gnt;
                    r0_n    = arb_gnt[REQ_BIST] ? op1 : op0;
                    chk_n   = arb_gnt[REQ_BIST] ? chk1 : chk0;
                    cnt_n   = CNT_LOAD;
                    busy_n  = 1'b1;
                    last_n  = arb_gnt[REQ_BIST];
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    res_q_n   = dp_q;
                    res_flt_n = {dp_out1, dp_out};
                    done_n    = 1'b1;
                    state_n   = CAPTURE;
                end
            end
            CAPTURE: begin
                done_n  = 1'b0;
                gnt_n   = 2'b00;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= 1'b1;  // "requester 1 won last" so the host wins first
            gnt      <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
            res_q    <= 1'b0;
            res_flt  <= '0;
            dp_r0    <= '0;
            dp_check <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            last     <= last_n;
            gnt      <= gnt_n;
            busy     <= busy_n;
            done     <= done_n;
            res_q    <= res_q_n;
            res_flt  <= res_flt_n;
            dp_r0    <= r0_n;
            dp_check <= chk_n;
        end
    end

`ifdef COPRO_SCHED_FAULT_LOG_EN
    logic flt_hit;
    assign flt_hit = (state == SETTLE) && (cnt == '0) && ({dp_out1, dp_out} != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            flt_cnt <= 8'd0;
        end else if (flt_hit && flt_cnt != 8'hFF) begin
            flt_cnt <= flt_cnt + 8'd1;
        end
    end
`endif

endmodule
